// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, one step per cycle.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle MULT/MULTU via '*').
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             md_valid_ex,
    input  logic [2:0]       md_op_ex,
    input  logic [WIDTH-1:0] rs_val_ex,
    input  logic [WIDTH-1:0] rt_val_ex,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             stall_req,
    output logic             md_done
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned DW    = 2 * WIDTH;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;  // negate product / quotient
    logic               neg_hi_q, neg_hi_d;  // negate remainder
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept;
    logic               is_mul_op, is_div_op, op_signed;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [DW-1:0]      mul_next, div_next, step_next, mul_res;
    logic [WIDTH-1:0]   quo_res, rem_res;
`ifdef MULDIV_FAST_MUL_EN
    logic [DW-1:0]      fast_prod;
`endif

    assign stall_req = busy & md_valid_ex & (md_op_ex != OP_NONE) & ~flush;
    assign accept    = md_valid_ex & ~flush & ~stall_req;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign busy      = (state_q == S_BUSY);
    assign md_done   = done_q;

    // Operand decode and magnitude preparation for signed ops
    always_comb begin
        is_mul_op = (md_op_ex == OP_MULT) | (md_op_ex == OP_MULTU);
        is_div_op = (md_op_ex == OP_DIV)  | (md_op_ex == OP_DIVU);
        op_signed = (md_op_ex == OP_MULT) | (md_op_ex == OP_DIV);
        rs_neg    = op_signed & rs_val_ex[WIDTH-1];
        rt_neg    = op_signed & rt_val_ex[WIDTH-1];
        rs_mag    = rs_neg ? WIDTH'(-rs_val_ex) : rs_val_ex;
        rt_mag    = rt_neg ? WIDTH'(-rt_val_ex) : rt_val_ex;
`ifdef MULDIV_FAST_MUL_EN
        if (op_signed)
            fast_prod = DW'($signed({{WIDTH{rs_val_ex[WIDTH-1]}}, rs_val_ex}) *
                            $signed({{WIDTH{rt_val_ex[WIDTH-1]}}, rt_val_ex}));
        else
            fast_prod = DW'({{WIDTH{1'b0}}, rs_val_ex} * {{WIDTH{1'b0}}, rt_val_ex});
`endif
    end

    // One radix-2 datapath step and final sign correction
    always_comb begin
        mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_diff  = div_shift[WIDTH-1:0] - opb_q;
        div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        step_next = is_div_q ? div_next : mul_next;
        mul_res   = neg_lo_q ? DW'(-step_next) : step_next;
        quo_res   = neg_lo_q ? WIDTH'(-step_next[WIDTH-1:0]) : step_next[WIDTH-1:0];
        rem_res   = neg_hi_q ? WIDTH'(-step_next[DW-1:WIDTH]) : step_next[DW-1:WIDTH];
    end

    // Next-state logic: start, iterate, write back, MTHI/MTLO
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
                    if (is_mul_op) begin
                        hi_d   = fast_prod[DW-1:WIDTH];
                        lo_d   = fast_prod[WIDTH-1:0];
                        done_d = 1'b1;
                    end
                    if (is_div_op) begin
`else
                    if (is_mul_op | is_div_op) begin
`endif
                        state_d  = S_BUSY;
                        cnt_d    = '0;
                        is_div_d = is_div_op;
                        // Divide by zero keeps an all-ones quotient unsigned
                        neg_lo_d = (rs_neg ^ rt_neg) & ~(is_div_op & (rt_val_ex == '0));
                        neg_hi_d = rs_neg;
                        opb_d    = is_div_op ? rt_mag : rs_mag;
                        acc_d    = is_div_op ? {{WIDTH{1'b0}}, rs_mag} : {{WIDTH{1'b0}}, rt_mag};
                    end
                    if (md_op_ex == OP_MTHI) hi_d = rs_val_ex;
                    if (md_op_ex == OP_MTLO) lo_d = rs_val_ex;
                end
            end
            S_BUSY: begin
                acc_d = step_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        hi_d = mul_res[DW-1:WIDTH];
                        lo_d = mul_res[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed cases plus random traffic against a
// cycle-level arithmetic model (countdown of remaining busy cycles).
module tb_ex_muldiv_unit;

    localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_BUSY = 32;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          md_valid_ex = 1'b0;
    logic [2:0]    md_op_ex = 3'b000;
    logic [W-1:0]  rs_val_ex = '0;
    logic [W-1:0]  rt_val_ex = '0;
    logic [W-1:0]  hi_out, lo_out;
    logic          busy, stall_req, md_done;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .md_valid_ex(md_valid_ex),
        .md_op_ex(md_op_ex), .rs_val_ex(rs_val_ex), .rt_val_ex(rt_val_ex),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .stall_req(stall_req),
        .md_done(md_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic        m_stall = 1'b0;

    // Stimulus for the next step
    logic        s_rst = 1'b1, s_fl = 1'b0, s_v = 1'b0;
    logic [2:0]  s_op = '0;
    logic [31:0] s_a = '0, s_b = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        int sx, sy;
        sx = int'(x);
        sy = int'(y);
        h = '0;
        l = '0;
        case (o)
            3'b001: begin p = 64'(longint'(sx) * longint'(sy)); {h, l} = p; end
            3'b010: begin p = 64'(x) * 64'(y); {h, l} = p; end
            3'b011: begin
                if (y == 0) begin l = '1; h = x; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin l = 32'h8000_0000; h = '0; end
                else begin l = 32'(sx / sy); h = 32'(sx % sy); end
            end
            3'b100: begin
                if (y == 0) begin l = '1; h = x; end
                else begin l = x / y; h = x % y; end
            end
            default: ;
        endcase
    endfunction

    task automatic drv(input logic rst, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic fl);
        s_rst = rst; s_v = v; s_op = op; s_a = a; s_b = b; s_fl = fl;
    endtask

    // One cycle: apply inputs, compare against model, advance model over the next edge
    task automatic step();
        logic acc;
        @(negedge clk);
        reset = s_rst; flush = s_fl; md_valid_ex = s_v; md_op_ex = s_op;
        rs_val_ex = s_a; rt_val_ex = s_b;
        #1;
        m_stall = (m_left > 0) && s_v && (s_op != 3'b000) && !s_fl;
        chk("hi", 64'(hi_out), 64'(m_hi));
        chk("lo", 64'(lo_out), 64'(m_lo));
        chk("busy", 64'(busy), 64'(m_left > 0));
        chk("done", 64'(md_done), 64'(m_done));
        chk("stall", 64'(stall_req), 64'(m_stall));
        if (s_rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
            end
            acc = s_v && !s_fl && !m_stall;
            if (acc) begin
                case (s_op)
                    3'b001, 3'b010: begin
                        ref_md(s_op, s_a, s_b, p_hi, p_lo);
                        if (MUL_BUSY == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
                        else m_left = MUL_BUSY;
                    end
                    3'b011, 3'b100: begin
                        ref_md(s_op, s_a, s_b, p_hi, p_lo);
                        m_left = 32;
                    end
                    3'b101: m_hi = s_a;
                    3'b110: m_lo = s_a;
                    default: ;
                endcase
            end
        end
    endtask

    // Issue one op, then idle for n cycles counting busy and done samples
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, output int nbusy, output int ndone);
        drv(0, 1, op, a, b, 0);
        step();
        drv(0, 0, 3'b000, $urandom, $urandom, 0);
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (busy) nbusy++;
            if (md_done) ndone++;
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [5];
        sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
        if ($urandom_range(3) == 0) return sp[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        int nb, nd, ns;

        // Reset state
        drv(1, 0, 3'b000, 0, 0, 0);
        step();
        step();
        chk("rst_hi", 64'(hi_out), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);

        // MULTU all-ones
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40, nb, nd);
        chk("multu_busy_cycles", 64'(nb), 64'(MUL_BUSY));
        chk("multu_done_pulses", 64'(nd), 64'd1);
        chk("multu_hi", 64'(hi_out), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo_out), 64'h0000_0001);

        // MULT -3 * 7
        run_op(3'b001, 32'hFFFF_FFFD, 32'd7, 40, nb, nd);
        chk("mult_hi", 64'(hi_out), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo_out), 64'hFFFF_FFEB);

        // DIV -7 / 2
        run_op(3'b011, 32'hFFFF_FFF9, 32'd2, 40, nb, nd);
        chk("div_busy_cycles", 64'(nb), 64'd32);
        chk("div_lo", 64'(lo_out), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi_out), 64'hFFFF_FFFF);

        // DIVU by zero
        run_op(3'b100, 32'd7, 32'd0, 40, nb, nd);
        chk("divu0_lo", 64'(lo_out), 64'hFFFF_FFFF);
        chk("divu0_hi", 64'(hi_out), 64'd7);

        // DIV overflow -2^31 / -1
        run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 40, nb, nd);
        chk("divovf_lo", 64'(lo_out), 64'h8000_0000);
        chk("divovf_hi", 64'(hi_out), 64'h0);

        // MULT then MFLO held in EX while stalled
        drv(0, 1, 3'b001, 32'd5, 32'd6, 0);
        step();
        drv(0, 1, 3'b111, 0, 0, 0);
        ns = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!stall_req) break;
            ns++;
        end
        chk("mflo_stall_cycles", 64'(ns), 64'(MUL_BUSY));
        chk("mflo_lo", 64'(lo_out), 64'd30);

        // MTHI while idle
        drv(0, 1, 3'b101, 32'h1234, 0, 0);
        step();
        drv(0, 0, 3'b000, 0, 0, 0);
        step();
        chk("mthi_hi", 64'(hi_out), 64'h1234);
        chk("mthi_busy", 64'(busy), 64'h0);

        // Flushed DIV must not start
        drv(0, 1, 3'b011, 32'd100, 32'd3, 1);
        step();
        drv(0, 0, 3'b000, 0, 0, 0);
        step();
        chk("flush_busy", 64'(busy), 64'h0);
        chk("flush_hi", 64'(hi_out), 64'h1234);
        chk("flush_lo", 64'(lo_out), 64'd30);

        // Reset in the middle of a DIVU, then a full MULTU
        run_op(3'b100, 32'd100, 32'd7, 9, nb, nd);
        drv(1, 0, 3'b000, 0, 0, 0);
        step();
        drv(0, 0, 3'b000, 0, 0, 0);
        step();
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_hi", 64'(hi_out), 64'h0);
        chk("midrst_lo", 64'(lo_out), 64'h0);
        run_op(3'b010, 32'd3, 32'd5, 40, nb, nd);
        chk("postrst_busy_cycles", 64'(nb), 64'(MUL_BUSY));
        chk("postrst_lo", 64'(lo_out), 64'd15);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drv(($urandom_range(299) == 0), ($urandom_range(4) != 0), 3'($urandom_range(7)),
                pick(), pick(), ($urandom_range(9) == 0));
            step();
        end
        drv(0, 0, 3'b000, 0, 0, 0);
        for (int i = 0; i < 40; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
